fetch_unit: RTL and testbench

- Instruction fetch stage of the single-issue RISC-V core. Directly upstream of decode and the immediate extender.
- Holds the fetch PC and issues one instruction-memory request at a time using a request/grant/response handshake.
- Presents the fetched instruction with its PC and PC+4 to decode using a valid/ready handshake.
- Handles branch/jump redirects, including discarding a fetch that is already in flight.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, one instruction
// held for decode until accepted, with redirects that can squash an in-flight fetch.
module fetch_unit #(
  parameter int               width    = 32,
  parameter logic [width-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REDIRECT,
  input  logic [width-1:0] PCTarget,
  output logic             IMEM_REQ,
  output logic [width-1:0] IMEM_ADDR,
  input  logic             IMEM_GNT,
  input  logic             IMEM_RVALID,
  input  logic [31:0]      IMEM_RDATA,
  output logic             VALID_D,
  input  logic             READY_D,
  output logic [31:0]      INSTR_D,
  output logic [width-1:0] PC_D,
  output logic [width-1:0] PCPlus4_D
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t           state_reg, state_next;
  logic [width-1:0] pc_f_reg, pc_f_next;
  logic [width-1:0] pc_inflight_reg, pc_inflight_next;
  logic             kill_reg, kill_next;
  logic             valid_reg, valid_next;
  logic [31:0]      instr_reg, instr_next;
  logic [width-1:0] pc_d_reg, pc_d_next;
  logic [width-1:0] pcplus4_reg, pcplus4_next;
  logic [width-1:0] target_aligned;

  // Low two target bits are forced to zero to keep fetches word aligned.
  assign target_aligned = PCTarget & ~{{(width-2){1'b0}}, 2'b11};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= REQ;
      pc_f_reg        <= RESET_PC;
      pc_inflight_reg <= '0;
      kill_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      instr_reg       <= NOP;
      pc_d_reg        <= '0;
      pcplus4_reg     <= width'(4);
    end else begin
      state_reg       <= state_next;
      pc_f_reg        <= pc_f_next;
      pc_inflight_reg <= pc_inflight_next;
      kill_reg        <= kill_next;
      valid_reg       <= valid_next;
      instr_reg       <= instr_next;
      pc_d_reg        <= pc_d_next;
      pcplus4_reg     <= pcplus4_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_f_next        = pc_f_reg;
    pc_inflight_next = pc_inflight_reg;
    kill_next        = kill_reg;
    valid_next       = valid_reg;
    instr_next       = instr_reg;
    pc_d_next        = pc_d_reg;
    pcplus4_next     = pcplus4_reg;
    case (state_reg)
      REQ: begin
        if (IMEM_GNT) begin
          pc_inflight_next = pc_f_reg;
          pc_f_next        = pc_f_reg + width'(4);
          kill_next        = REDIRECT;
          state_next       = WAIT;
        end
      end
      WAIT: begin
        if (IMEM_RVALID) begin
          if (kill_reg || REDIRECT) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            instr_next   = IMEM_RDATA;
            pc_d_next    = pc_inflight_reg;
            pcplus4_next = pc_inflight_reg + width'(4);
            valid_next   = 1'b1;
            state_next   = HOLD;
          end
        end else if (REDIRECT) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        // A redirect flushes the held instruction even if decode accepts it.
        if (REDIRECT || READY_D) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
    if (REDIRECT) pc_f_next = target_aligned;
  end

  assign IMEM_REQ  = (state_reg == REQ) && RST_N;
  assign IMEM_ADDR = pc_f_reg;
  assign VALID_D   = valid_reg;
  assign INSTR_D   = instr_reg;
  assign PC_D      = pc_d_reg;
  assign PCPlus4_D = pcplus4_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand sequences for
// mid-fetch reset and the PC wrap at the top of the address space.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        redirect, gnt, rvalid, ready;
  logic [31:0] target, rdata;
  logic        req, valid;
  logic [31:0] addr, instr, pc_d, pc4_d;

  logic        gnt_w, rvalid_w, ready_w, redirect_w;
  logic [31:0] target_w, rdata_w;
  logic        req_w, valid_w;
  logic [31:0] addr_w, instr_w, pc_d_w, pc4_d_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.width(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .REDIRECT(redirect), .PCTarget(target),
    .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_GNT(gnt), .IMEM_RVALID(rvalid),
    .IMEM_RDATA(rdata), .VALID_D(valid), .READY_D(ready), .INSTR_D(instr),
    .PC_D(pc_d), .PCPlus4_D(pc4_d)
  );

  fetch_unit #(.width(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .REDIRECT(redirect_w), .PCTarget(target_w),
    .IMEM_REQ(req_w), .IMEM_ADDR(addr_w), .IMEM_GNT(gnt_w), .IMEM_RVALID(rvalid_w),
    .IMEM_RDATA(rdata_w), .VALID_D(valid_w), .READY_D(ready_w), .INSTR_D(instr_w),
    .PC_D(pc_d_w), .PCPlus4_D(pc4_d_w)
  );

  typedef struct packed {
    logic        redirect;
    logic [31:0] target;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rd, input logic [31:0] tg, input logic g,
                              input logic rv, input logic [31:0] d, input logic rdy,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ep4);
    vec_t v;
    v = '{rd, tg, g, rv, d, rdy, er, ea, ev, ei, ep, ep4};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                           input logic [31:0] ep4);
    check({tag, ".req"},   {31'b0, req},   {31'b0, er});
    check({tag, ".addr"},  addr,           ea);
    check({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
    check({tag, ".instr"}, instr,          ei);
    check({tag, ".pc"},    pc_d,           ep);
    check({tag, ".pc4"},   pc4_d,          ep4);
  endtask

  initial begin
    // Each row: inputs driven this cycle, outputs expected before the next rising edge.
    //            rd tgt          g  rv rdata         rdy  req addr         v  instr         pc           pc4
    vecs[0]  = mk(0, 0,           1, 0, 0,            0,   1, 32'h0,        0, 32'h13,       32'h0,       32'h4);
    vecs[1]  = mk(0, 0,           0, 1, 32'h00500093, 0,   0, 32'h4,        0, 32'h13,       32'h0,       32'h4);
    vecs[2]  = mk(0, 0,           0, 0, 0,            1,   0, 32'h4,        1, 32'h00500093, 32'h0,       32'h4);
    vecs[3]  = mk(0, 0,           0, 0, 0,            0,   1, 32'h4,        0, 32'h00500093, 32'h0,       32'h4);
    vecs[4]  = mk(0, 0,           1, 0, 0,            0,   1, 32'h4,        0, 32'h00500093, 32'h0,       32'h4);
    vecs[5]  = mk(0, 0,           0, 1, 32'h00A00113, 0,   0, 32'h8,        0, 32'h00500093, 32'h0,       32'h4);
    vecs[6]  = mk(0, 0,           0, 0, 0,            0,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[7]  = mk(0, 0,           0, 1, 32'hFFFFFFFF, 0,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[8]  = mk(0, 0,           0, 0, 0,            0,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[9]  = mk(0, 0,           0, 0, 0,            0,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[10] = mk(0, 0,           0, 0, 0,            0,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[11] = mk(0, 0,           0, 0, 0,            1,   0, 32'h8,        1, 32'h00A00113, 32'h4,       32'h8);
    vecs[12] = mk(0, 0,           1, 0, 0,            0,   1, 32'h8,        0, 32'h00A00113, 32'h4,       32'h8);
    vecs[13] = mk(1, 32'h103,     0, 0, 0,            0,   0, 32'hC,        0, 32'h00A00113, 32'h4,       32'h8);
    vecs[14] = mk(0, 0,           0, 1, 32'hDEADBEEF, 0,   0, 32'h100,      0, 32'h00A00113, 32'h4,       32'h8);
    vecs[15] = mk(0, 0,           0, 0, 0,            0,   1, 32'h100,      0, 32'h00A00113, 32'h4,       32'h8);
    vecs[16] = mk(1, 32'h8,       0, 0, 0,            0,   1, 32'h100,      0, 32'h00A00113, 32'h4,       32'h8);
    vecs[17] = mk(1, 32'h40,      1, 0, 0,            0,   1, 32'h8,        0, 32'h00A00113, 32'h4,       32'h8);
    vecs[18] = mk(0, 0,           0, 0, 0,            0,   0, 32'h40,       0, 32'h00A00113, 32'h4,       32'h8);
    vecs[19] = mk(0, 0,           0, 1, 32'h11111111, 0,   0, 32'h40,       0, 32'h00A00113, 32'h4,       32'h8);
    vecs[20] = mk(0, 0,           1, 0, 0,            0,   1, 32'h40,       0, 32'h00A00113, 32'h4,       32'h8);
    vecs[21] = mk(0, 0,           0, 1, 32'h00108093, 0,   0, 32'h44,       0, 32'h00A00113, 32'h4,       32'h8);
    vecs[22] = mk(1, 32'h200,     0, 0, 0,            0,   0, 32'h44,       1, 32'h00108093, 32'h40,      32'h44);
    vecs[23] = mk(1, 32'h300,     1, 0, 0,            0,   1, 32'h200,      0, 32'h00108093, 32'h40,      32'h44);
    vecs[24] = mk(1, 32'h404,     0, 0, 0,            0,   0, 32'h300,      0, 32'h00108093, 32'h40,      32'h44);
    vecs[25] = mk(0, 0,           0, 1, 32'h22222222, 0,   0, 32'h404,      0, 32'h00108093, 32'h40,      32'h44);
    vecs[26] = mk(0, 0,           0, 0, 0,            0,   1, 32'h404,      0, 32'h00108093, 32'h40,      32'h44);

    RST_N = 1'b0;
    redirect = 0; target = 0; gnt = 0; rvalid = 0; rdata = 0; ready = 0;
    redirect_w = 0; target_w = 0; gnt_w = 0; rvalid_w = 0; rdata_w = 0; ready_w = 0;

    repeat (2) @(negedge CLK);
    #1;
    check_all("reset", 0, 32'h0, 0, 32'h13, 32'h0, 32'h4);
    check("reset_w.addr", addr_w, 32'hFFFF_FFFC);
    check("reset_w.pc4", pc4_d_w, 32'h4);
    $display("reset: req=%0b addr=%h valid=%0b instr=%h", req, addr, valid, instr);

    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      redirect = vecs[i].redirect; target = vecs[i].target;
      gnt = vecs[i].gnt; rvalid = vecs[i].rvalid; rdata = vecs[i].rdata;
      ready = vecs[i].ready;
      #1;
      $display("vec %0d: rd=%0b g=%0b rv=%0b rdy=%0b -> req=%0b addr=%h valid=%0b instr=%h pc=%h pc4=%h",
               i, redirect, gnt, rvalid, ready, req, addr, valid, instr, pc_d, pc4_d);
      check_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4);
      @(negedge CLK);
    end
    redirect = 0; gnt = 0; rvalid = 0; ready = 0;

    // Reset pulsed while a fetch is in flight; the late response must be ignored.
    gnt = 1;
    #1;
    check("rst_mid.grant_req", {31'b0, req}, 32'h1);
    @(negedge CLK);
    gnt = 0;
    RST_N = 1'b0;
    #1;
    $display("reset mid-WAIT: req=%0b addr=%h valid=%0b", req, addr, valid);
    check_all("rst_mid.async", 0, 32'h0, 0, 32'h13, 32'h0, 32'h4);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_all("rst_rel", 1, 32'h0, 0, 32'h13, 32'h0, 32'h4);
    @(negedge CLK);
    rvalid = 1; rdata = 32'hAAAA_AAAA;
    #1;
    $display("late rvalid: req=%0b addr=%h valid=%0b", req, addr, valid);
    check_all("late_rv", 1, 32'h0, 0, 32'h13, 32'h0, 32'h4);
    @(negedge CLK);
    rvalid = 0;
    #1;
    check_all("after_late_rv", 1, 32'h0, 0, 32'h13, 32'h0, 32'h4);

    // Wrap at the top of the address space on the second instance.
    gnt_w = 1;
    #1;
    check("wrap.req", {31'b0, req_w}, 32'h1);
    check("wrap.addr0", addr_w, 32'hFFFF_FFFC);
    @(negedge CLK);
    gnt_w = 0; rvalid_w = 1; rdata_w = 32'h0010_0073;
    #1;
    check("wrap.addr_next", addr_w, 32'h0);
    @(negedge CLK);
    rvalid_w = 0; ready_w = 1;
    #1;
    $display("wrap: valid=%0b instr=%h pc=%h pc4=%h addr=%h", valid_w, instr_w, pc_d_w, pc4_d_w, addr_w);
    check("wrap.valid", {31'b0, valid_w}, 32'h1);
    check("wrap.instr", instr_w, 32'h0010_0073);
    check("wrap.pc", pc_d_w, 32'hFFFF_FFFC);
    check("wrap.pc4", pc4_d_w, 32'h0);
    @(negedge CLK);
    ready_w = 0;
    #1;
    check("wrap.req_after", {31'b0, req_w}, 32'h1);
    check("wrap.addr_after", addr_w, 32'h0);
    check("wrap.valid_after", {31'b0, valid_w}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
